// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, oversample edge counting,
// LSB-first deserialisation, parity/stop checking and byte hand-off.
module uart_rx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [5:0]        prescale,
  input  logic              sampled_bit,
  input  logic              sampling_done,
  output logic              dat_sam_en,
  output logic [5:0]        edge_count,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);

  localparam int CNT_W = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Expected parity bit for the data word: even -> XOR of data, odd -> inverted.
  function automatic logic parity_fn(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t              state_r, state_s;
  logic [5:0]          edge_r, edge_s;
  logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic [DATA_W-1:0]   p_data_r, p_data_s;
  logic                par_err_r, par_err_s;
  logic                stp_err_r, stp_err_s;
  logic                data_valid_r, data_valid_s;
  logic                dat_sam_en_r;
  logic [5:0]          last_edge_s;
  logic                bit_end_s;

  assign last_edge_s = prescale - 6'd1;
  assign bit_end_s   = (edge_r == last_edge_s);

  // Frame sequencing, deserialisation and error/valid decisions.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shift_s      = shift_r;
    p_data_s     = p_data_r;
    par_err_s    = par_err_r;
    stp_err_s    = stp_err_r;
    data_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        bit_cnt_s = {CNT_W{1'b0}};
        if (!RX_IN) begin
          state_s   = START;
          par_err_s = 1'b0;
          stp_err_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (sampling_done && sampled_bit) begin
          state_s = IDLE;
        end else if (bit_end_s) begin
          state_s   = DATA;
          bit_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (sampling_done) begin
          shift_s = {sampled_bit, shift_r[DATA_W-1:1]};
        end else begin
          shift_s = shift_r;
        end
        if (bit_end_s) begin
          bit_cnt_s = bit_cnt_r + CNT_ONE;
          if (bit_cnt_r == LAST_BIT) begin
            state_s = PAR_EN ? PARITY : STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (sampling_done) begin
          par_err_s = sampled_bit ^ parity_fn(shift_r, PAR_TYP);
        end else begin
          par_err_s = par_err_r;
        end
        if (bit_end_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (sampling_done) begin
          stp_err_s = ~sampled_bit;
        end else begin
          stp_err_s = stp_err_r;
        end
        // Use the updated stop flag so a stop sample on the last edge still counts.
        if (bit_end_s) begin
          state_s = IDLE;
          if (!par_err_r && !stp_err_s) begin
            p_data_s     = shift_r;
            data_valid_s = 1'b1;
          end else begin
            data_valid_s = 1'b0;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Oversample edge counter: parked at zero while idle or returning to idle.
  always_comb begin
    edge_s = edge_r;
    if ((state_r == IDLE) || (state_s == IDLE)) begin
      edge_s = 6'd0;
    end else if (bit_end_s) begin
      edge_s = 6'd0;
    end else begin
      edge_s = edge_r + 6'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= IDLE;
      edge_r       <= 6'd0;
      bit_cnt_r    <= {CNT_W{1'b0}};
      shift_r      <= {DATA_W{1'b0}};
      p_data_r     <= {DATA_W{1'b0}};
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
      data_valid_r <= 1'b0;
      dat_sam_en_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      edge_r       <= edge_s;
      bit_cnt_r    <= bit_cnt_s;
      shift_r      <= shift_s;
      p_data_r     <= p_data_s;
      par_err_r    <= par_err_s;
      stp_err_r    <= stp_err_s;
      data_valid_r <= data_valid_s;
      dat_sam_en_r <= (state_s != IDLE);
    end
  end

  assign dat_sam_en = dat_sam_en_r;
  assign edge_count = edge_r;
  assign P_DATA     = p_data_r;
  assign data_valid = data_valid_r;
  assign par_err    = par_err_r;
  assign stp_err    = stp_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural mid-bit sampler.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       sampled_bit;
  logic       sampling_done;
  logic       dat_sam_en;
  logic [5:0] edge_count;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_ctrl #(.DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .prescale(prescale), .sampled_bit(sampled_bit), .sampling_done(sampling_done),
    .dat_sam_en(dat_sam_en), .edge_count(edge_count), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  // Sampler stand-in: strobes at edge prescale/2+1 (5 for prescale 8).
  assign sampling_done = dat_sam_en && (edge_count == ((prescale >> 1) + 6'd1));
  assign sampled_bit   = RX_IN;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } exp_t;
  exp_t sb_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected frame.
  always @(negedge CLK) begin
    if (RST && data_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got data_valid=1 P_DATA=0x%0h expected no pulse", P_DATA);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
        check("valid_cycle", cyc, e.cycle);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    RX_IN = v;
    wait_cyc(n);
  endtask

  // start_off: cycles from first low drive to first START cycle; lat: hand-computed frame length.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input bit exp_valid, input int start_off, input int lat);
    int c0;
    int ps;
    c0 = cyc;
    ps = int'(prescale);
    if (exp_valid) sb_q.push_back(exp_t'{data: d, cycle: c0 + start_off + lat});
    drive(1'b0, ps);
    for (int i = 0; i < 8; i++) drive(d[i], ps);
    if (PAR_EN) drive(pbit, ps);
    drive(sbit, ps);
    RX_IN = 1'b1;
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_p_data", {24'd0, P_DATA}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_par_err", {31'd0, par_err}, 32'd0);
    check("rst_stp_err", {31'd0, stp_err}, 32'd0);
    check("rst_sam_en", {31'd0, dat_sam_en}, 32'd0);
    check("rst_edge", {26'd0, edge_count}, 32'd0);
    @(negedge CLK) RST = 1'b1;
    wait_cyc(4);

    // prescale 8, no parity, 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1, 80);
    wait_cyc(16);
    check("a5_par_err", {31'd0, par_err}, 32'd0);
    check("a5_stp_err", {31'd0, stp_err}, 32'd0);
    check("a5_sam_en_idle", {31'd0, dat_sam_en}, 32'd0);

    // prescale 16, even parity, 0x37 good then bad parity
    prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    wait_cyc(8);
    send_frame(8'h37, 1'b1, 1'b1, 1'b1, 1, 176);
    wait_cyc(32);
    check("p37_par_err", {31'd0, par_err}, 32'd0);
    send_frame(8'h37, 1'b0, 1'b1, 1'b0, 1, 0);
    wait_cyc(32);
    check("p37bad_par_err", {31'd0, par_err}, 32'd1);
    check("p37bad_stp_err", {31'd0, stp_err}, 32'd0);
    check("p37bad_p_data", {24'd0, P_DATA}, 32'h37);

    // prescale 8, odd parity, 0xFF with stop bit 0
    prescale = 6'd8;
    PAR_TYP  = 1'b1;
    wait_cyc(8);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1, 0);
    wait_cyc(16);
    check("ff_stp_err", {31'd0, stp_err}, 32'd1);
    check("ff_par_err", {31'd0, par_err}, 32'd0);
    check("ff_p_data", {24'd0, P_DATA}, 32'h37);

    // glitch: two low cycles, false start
    PAR_EN = 1'b0;
    drive(1'b0, 2);
    RX_IN = 1'b1;
    check("glitch_sam_en_on", {31'd0, dat_sam_en}, 32'd1);
    check("glitch_stp_clr", {31'd0, stp_err}, 32'd0);
    wait_cyc(8);
    check("glitch_sam_en_off", {31'd0, dat_sam_en}, 32'd0);
    check("glitch_edge", {26'd0, edge_count}, 32'd0);
    check("glitch_par_err", {31'd0, par_err}, 32'd0);
    wait_cyc(16);

    // prescale 32, back-to-back 0x00 then 0x81
    prescale = 6'd32;
    wait_cyc(8);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1, 320);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 2, 320);
    wait_cyc(64);
    check("b2b_p_data", {24'd0, P_DATA}, 32'h81);

    // reset during DATA bit 4, then clean 0x5A
    prescale = 6'd8;
    wait_cyc(8);
    drive(1'b0, 8);
    for (int i = 0; i < 4; i++) drive(1'b1, 8);
    wait_cyc(4);
    check("mid_sam_en", {31'd0, dat_sam_en}, 32'd1);
    check("mid_edge", {26'd0, edge_count}, 32'd3);
    RST   = 1'b0;
    #1;
    check("mrst_p_data", {24'd0, P_DATA}, 32'd0);
    check("mrst_sam_en", {31'd0, dat_sam_en}, 32'd0);
    check("mrst_edge", {26'd0, edge_count}, 32'd0);
    check("mrst_valid", {31'd0, data_valid}, 32'd0);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    wait_cyc(8);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1, 80);
    wait_cyc(16);
    check("5a_p_data", {24'd0, P_DATA}, 32'h5A);
    check("5a_stp_err", {31'd0, stp_err}, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
